bus_master_arb: RTL and testbench

- Round-robin master-side controller for the dValid/dAck/data 8-bit transfer bus.
- Arbitrates NREQ local requesters onto one bus master port and holds data stable for the whole transfer.
- Keeps dValid high for 2 to 4 clocks and drops it the clock after dAck.
- Flags target protocol violations: early ack and missing ack.

---
 rtl/bus_master_arb.sv | 147 ++++++++++++++
 tb/tb_bus_master_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arb.sv
// Round-robin master for the dValid/dAck/data transfer bus: arbitrates NREQ
// requesters, holds data for the transfer, and flags early/missing target acks.
module bus_master_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int MINV = 2,
    parameter int MAXV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               dValid,
    output logic [DW-1:0]      data,
    input  logic               dAck,
    output logic               busy,
    output logic               err_early,
    output logic               err_timeout
);

    localparam int CW = $clog2(MAXV + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] MINV_C = CW'(MINV);
    localparam logic [CW-1:0] MAXV_C = CW'(MAXV);

    typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_GAP} state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [PW-1:0]   r_ptr, w_ptr;
    logic [NREQ-1:0] r_grant, w_grant;
    logic [NREQ-1:0] r_done, w_done;
    logic            r_dvalid, w_dvalid;
    logic [DW-1:0]   r_data, w_data;
    logic            r_busy;
    logic            r_err_early, w_err_early;
    logic            r_err_tmo, w_err_tmo;

    logic            w_found;
    logic [PW-1:0]   w_sel;
    logic [PW-1:0]   w_sel_next;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_sel   = PW'(idx);
            end
        end
        w_sel_next = (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves one unassigned (no latches).
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ptr       = r_ptr;
        w_grant     = r_grant;
        w_done      = '0;
        w_dvalid    = r_dvalid;
        w_data      = r_data;
        w_err_early = 1'b0;
        w_err_tmo   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_dvalid = 1'b1;
                    w_data   = req_data[int'(w_sel)*DW +: DW];
                    w_grant  = NREQ'(1) << w_sel;
                    w_cnt    = CW'(1);
                    w_ptr    = w_sel_next;
                    w_state  = ST_VALID;
                end
            end
            ST_VALID: begin
                if (dAck && r_cnt == CW'(1)) begin
                    w_err_early = 1'b1;
                    w_cnt       = CW'(2);
                end else if (dAck && r_cnt >= MINV_C) begin
                    w_dvalid = 1'b0;
                    w_done   = r_grant;
                    w_state  = ST_GAP;
                end else if (!dAck && r_cnt == MAXV_C) begin
                    w_dvalid  = 1'b0;
                    w_done    = r_grant;
                    w_err_tmo = 1'b1;
                    w_state   = ST_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                // Guaranteed low cycle so the next transfer starts on a fresh dValid rise.
                w_grant = '0;
                w_cnt   = '0;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_dvalid    <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_err_early <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ptr       <= w_ptr;
            r_grant     <= w_grant;
            r_done      <= w_done;
            r_dvalid    <= w_dvalid;
            r_data      <= w_data;
            r_busy      <= (w_state != ST_IDLE);
            r_err_early <= w_err_early;
            r_err_tmo   <= w_err_tmo;
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign dValid      = r_dvalid;
    assign data        = r_data;
    assign busy        = r_busy;
    assign err_early   = r_err_early;
    assign err_timeout = r_err_tmo;

endmodule

// File: tb/tb_bus_master_arb.sv
// Self-checking bench for bus_master_arb: transfer-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bus_master_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MINV = 2;
    localparam int MAXV = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic               dAck = 1'b0;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               dValid;
    logic [DW-1:0]      data;
    logic               busy;
    logic               err_early;
    logic               err_timeout;

    bus_master_arb #(.NREQ(NREQ), .DW(DW), .MINV(MINV), .MAXV(MAXV)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .dValid(dValid), .data(data),
        .dAck(dAck), .busy(busy), .err_early(err_early), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transfer at a time, tracked as owner + beats seen.
    int              m_owner = -1;
    int              m_beats = 0;
    int              m_ptr   = 0;
    bit              m_gap   = 1'b0;
    bit              m_early = 1'b0;
    bit              m_tmo   = 1'b0;
    logic [DW-1:0]   m_data  = '0;

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1; m_beats = 0; m_ptr = 0; m_gap = 1'b0;
            m_early = 1'b0; m_tmo = 1'b0; m_data = '0;
        end else begin
            m_early = 1'b0;
            m_tmo   = 1'b0;
            if (m_owner < 0) begin
                m_owner = pick(req, m_ptr);
                if (m_owner >= 0) begin
                    m_data  = req_data[m_owner*DW +: DW];
                    m_beats = 1;
                    m_ptr   = (m_owner + 1) % NREQ;
                end
            end else if (m_gap) begin
                m_owner = -1;
                m_gap   = 1'b0;
            end else if (dAck && m_beats == 1) begin
                m_early = 1'b1;
                m_beats = 2;
            end else if (dAck && m_beats >= MINV) begin
                m_gap = 1'b1;
            end else if (m_beats == MAXV) begin
                m_gap = 1'b1;
                m_tmo = 1'b1;
            end else begin
                m_beats++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] e_grant;
            bit e_dv;
            e_dv    = (m_owner >= 0) && !m_gap;
            e_grant = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
            check("dValid", dValid, e_dv);
            check("grant", grant, e_grant);
            check("done", done, m_gap ? e_grant : 64'd0);
            check("busy", busy, m_owner >= 0);
            check("err_early", err_early, m_early);
            check("err_timeout", err_timeout, m_tmo);
            if (e_dv || !reset) check("data", data, m_data);
        end
    end

    // Target: acks from dValid cycle ack_at onward (0 = never); optional ack while idle.
    int ack_at   = 2;
    bit spurious = 1'b0;
    int acyc     = 0;
    initial forever begin
        @(negedge clk);
        if (dValid) begin
            acyc++;
            dAck = (ack_at != 0) && (acyc >= ack_at);
        end else begin
            acyc = 0;
            dAck = spurious;
        end
    end

    // Observation of DUT behaviour for the directed literal checks.
    int   rise_q[$];
    int   len_q[$];
    int   gap_q[$];
    int   data_q[$];
    int   hi_run = 0, low_run = 0;
    int   n_early = 0, n_tmo = 0, n_done = 0;
    logic prev_dv = 1'b0;

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (dValid) begin
            if (!prev_dv) begin
                rise_q.push_back(onehot_idx(grant));
                data_q.push_back(int'(data));
                gap_q.push_back(low_run);
            end
            hi_run++;
            low_run = 0;
        end else begin
            if (prev_dv) len_q.push_back(hi_run);
            hi_run = 0;
            low_run++;
        end
        if (err_early)   n_early++;
        if (err_timeout) n_tmo++;
        if (done != 0)   n_done++;
        prev_dv = dValid;
    end

    task automatic clear_rec();
        rise_q.delete(); len_q.delete(); gap_q.delete(); data_q.delete();
        n_early = 0; n_tmo = 0; n_done = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done != 0) seen = 1'b1;
        end
        check(name, seen, 1'b1);
    endtask

    task automatic wait_rise(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (dValid) seen = 1'b1;
        end
        check(name, seen, 1'b1);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Ack in cycle 2: two-cycle transfer from requester 0.
        clear_rec();
        ack_at = 2;
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        wait_done("t1_done");
        req = '0;
        repeat (2) step();
        check("t1_len", len_q.size() == 1 ? len_q[0] : -1, 2);
        check("t1_owner", rise_q.size() == 1 ? rise_q[0] : -1, 0);
        check("t1_data", data_q.size() == 1 ? data_q[0] : -1, 32'hA5);
        check("t1_errs", n_early + n_tmo, 0);

        // Ack first in cycle 4 == MAXV: completes normally, no timeout.
        clear_rec();
        ack_at = 4;
        req_data[15:8] = 8'h3C;
        req = 4'b0010;
        wait_done("t2_done");
        req = '0;
        repeat (2) step();
        check("t2_len", len_q.size() == 1 ? len_q[0] : -1, 4);
        check("t2_owner", rise_q.size() == 1 ? rise_q[0] : -1, 1);
        check("t2_data", data_q.size() == 1 ? data_q[0] : -1, 32'h3C);
        check("t2_tmo", n_tmo, 0);

        // No ack at all: timeout, then requester 3 follows after the minimum gap.
        clear_rec();
        ack_at = 0;
        req_data[23:16] = 8'h5A;
        req_data[31:24] = 8'hC3;
        req = 4'b1100;
        wait_done("t3_done_a");
        req = 4'b1000;
        wait_done("t3_done_b");
        req = '0;
        repeat (2) step();
        check("t3_len0", len_q.size() == 2 ? len_q[0] : -1, 4);
        check("t3_len1", len_q.size() == 2 ? len_q[1] : -1, 4);
        check("t3_tmo", n_tmo, 2);
        check("t3_order", rise_q.size() == 2 ? {rise_q[0][7:0], rise_q[1][7:0]} : 16'hFFFF, 16'h0203);
        check("t3_gap", gap_q.size() == 2 ? gap_q[1] : -1, 2);

        // Three held requests: strict round-robin 0,1,3,0.
        clear_rec();
        ack_at = 2;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1011;
        for (int t = 0; t < 4; t++) wait_done("t4_done");
        req = '0;
        repeat (2) step();
        check("t4_count", rise_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            int exp_own;
            exp_own = (i == 2) ? 3 : ((i == 1) ? 1 : 0);
            check("t4_owner", i < rise_q.size() ? rise_q[i] : -1, exp_own);
            check("t4_data", i < data_q.size() ? data_q[i] : -1, 32'h11 * (exp_own + 1));
            check("t4_len", i < len_q.size() ? len_q[i] : -1, 2);
            if (i > 0) check("t4_gap_ge1", i < gap_q.size() ? (gap_q[i] >= 1) : 0, 1);
        end

        // Ack in cycle 1 and held, with dAck also high while idle: one early error.
        clear_rec();
        spurious = 1'b1;
        ack_at = 1;
        repeat (2) step();
        req_data[7:0] = 8'h77;
        req = 4'b0001;
        wait_done("t5_done");
        req = '0;
        repeat (2) step();
        spurious = 1'b0;
        step();
        check("t5_early", n_early, 1);
        check("t5_len", len_q.size() == 1 ? len_q[0] : -1, 2);
        check("t5_tmo", n_tmo, 0);

        // Reset in dValid cycle 2 aborts silently; pointer restarts at 0.
        ack_at = 0;
        req_data[15:8] = 8'h99;
        req = 4'b0010;
        wait_rise("t6_rise");
        step();
        clear_rec();
        req = 4'b0111;
        #2 reset = 1'b0;
        #1;
        check("t6_rst_dvalid", dValid, 1'b0);
        check("t6_rst_grant", grant, 4'b0000);
        check("t6_rst_data", data, 8'h00);
        check("t6_rst_busy", busy, 1'b0);
        repeat (2) step();
        req = 4'b0101;
        ack_at = 2;
        reset = 1'b1;
        wait_rise("t6_rise2");
        check("t6_first_owner", rise_q.size() >= 1 ? rise_q[0] : -1, 0);
        check("t6_no_done", n_done, 0);
        wait_done("t6_done_a");
        req = 4'b0100;
        wait_done("t6_done_b");
        req = '0;
        repeat (2) step();
        check("t6_second_owner", rise_q.size() == 2 ? rise_q[1] : -1, 2);
        check("t6_errs", n_early + n_tmo, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1, "watchdog expired");
    end

endmodule
